// File: rtl/shift_arbiter_pkg.sv
// Shared widths and result-slot state encoding for the shift arbiter slice.
package shift_arbiter_pkg;

    localparam int SH_W = 32;
    localparam int SA_W = 5;

    typedef enum logic {
        SA_EMPTY = 1'b0,
        SA_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right or arithmetic right.
module barrel_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [SH_W-1:0] d,
    input  logic [SA_W-1:0] sa,
    input  logic            right,
    input  logic            arith,
    output logic [SH_W-1:0] sh
);

    // Arithmetic fill only applies to right shifts; left shifts always fill zeros.
    always_comb begin
        sh = d << sa;
        if (right) begin
            if (arith) begin
                sh = $signed(d) >>> sa;
            end else begin
                sh = d >> sa;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    // k is the search distance from the pointer; j is the requester it maps to.
    always_comb begin
        int  j;
        logic found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == j && i_en && !found && i_req[i]) begin
                    o_gnt[i] = 1'b1;
                    o_idx    = IDW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter among NREQ requesters with round-robin grant
// and a single registered, id-tagged result slot.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [SH_W*NREQ-1:0] req_d,
    input  logic [SA_W*NREQ-1:0] req_sa,
    input  logic [NREQ-1:0]      req_right,
    input  logic [NREQ-1:0]      req_arith,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SH_W-1:0]      res_sh,
    output logic [IDW-1:0]       res_id
);

    slot_state_t     r_state;
    logic [IDW-1:0]  r_rrPtr;
    logic [SH_W-1:0] r_resSh;
    logic [IDW-1:0]  r_resId;

    logic            w_slotFree;
    logic            w_grantEn;
    logic            w_anyGrant;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_nextPtr;
    logic [SH_W-1:0] w_d;
    logic [SA_W-1:0] w_sa;
    logic            w_right;
    logic            w_arith;
    logic [SH_W-1:0] w_sh;

    // The slot can take a new result when empty or when the held one drains this cycle.
    assign w_slotFree = (r_state == SA_EMPTY) | res_ready;
    assign w_grantEn  = w_slotFree & ~reset;
    assign w_anyGrant = |w_gnt;
    assign w_nextPtr  = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rrArbiter (
        .i_req (req_valid),
        .i_ptr (r_rrPtr),
        .i_en  (w_grantEn),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_comb begin
        w_d     = '0;
        w_sa    = '0;
        w_right = 1'b0;
        w_arith = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_d     = req_d[SH_W*i +: SH_W];
                w_sa    = req_sa[SA_W*i +: SA_W];
                w_right = req_right[i];
                w_arith = req_arith[i];
            end
        end
    end

    barrel_shifter u_barrelShifter (
        .d     (w_d),
        .sa    (w_sa),
        .right (w_right),
        .arith (w_arith),
        .sh    (w_sh)
    );

    // A grant always loads the slot, which also covers drain-and-refill in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SA_EMPTY;
            r_rrPtr <= '0;
            r_resSh <= '0;
            r_resId <= '0;
        end else begin
            case (r_state)
                SA_EMPTY: begin
                    if (w_anyGrant) begin
                        r_state <= SA_FULL;
                    end
                end
                SA_FULL: begin
                    if (res_ready && !w_anyGrant) begin
                        r_state <= SA_EMPTY;
                    end
                end
                default: r_state <= SA_EMPTY;
            endcase
            if (w_anyGrant) begin
                r_resSh <= w_sh;
                r_resId <= w_idx;
                r_rrPtr <= w_nextPtr;
            end
        end
    end

    assign req_ready = w_gnt;
    assign res_valid = (r_state == SA_FULL);
    assign res_sh    = r_resSh;
    assign res_id    = r_resId;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: table of single-requester shifts plus
// hand-written reset, round-robin, stall and reset-while-full sequences.
module tb_shift_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] reqD;
    logic [9:0]  reqSa;
    logic [1:0]  reqRight;
    logic [1:0]  reqArith;
    logic        resValid;
    logic        resReady;
    logic [31:0] resSh;
    logic [0:0]  resId;

    int total;
    int bad;

    typedef struct {
        int          id;
        logic [31:0] d;
        logic [4:0]  sa;
        logic        right;
        logic        arith;
        logic [31:0] expSh;
    } vec_t;

    vec_t vecs[10];

    shift_arbiter #(
        .NREQ (2),
        .IDW  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_d     (reqD),
        .req_sa    (reqSa),
        .req_right (reqRight),
        .req_arith (reqArith),
        .res_valid (resValid),
        .res_ready (resReady),
        .res_sh    (resSh),
        .res_id    (resId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic rdy,
                                 input logic [31:0] d0, input logic [4:0] sa0, input logic r0, input logic a0,
                                 input logic [31:0] d1, input logic [4:0] sa1, input logic r1, input logic a1);
        reqValid = valid;
        resReady = rdy;
        reqD     = {d1, d0};
        reqSa    = {sa1, sa0};
        reqRight = {r1, r0};
        reqArith = {a1, a0};
    endtask

    initial begin
        logic [1:0]  expReady;
        logic [31:0] expSh;
        total = 0;
        bad   = 0;

        vecs[0] = '{0, 32'h0000_00F0, 5'd4,  1'b0, 1'b0, 32'h0000_0F00};
        vecs[1] = '{1, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{1, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001};
        vecs[3] = '{0, 32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678};
        vecs[4] = '{1, 32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678};
        vecs[5] = '{0, 32'h8000_0001, 5'd1,  1'b0, 1'b1, 32'h0000_0002};
        vecs[6] = '{1, 32'hF000_0000, 5'd4,  1'b1, 1'b1, 32'hFF00_0000};
        vecs[7] = '{0, 32'hF000_0000, 5'd4,  1'b1, 1'b0, 32'h0F00_0000};
        vecs[8] = '{1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000};
        vecs[9] = '{0, 32'h7FFF_FFFF, 5'd31, 1'b1, 1'b1, 32'h0000_0000};

        // Reset held with both requesters valid.
        reset = 1'b1;
        applyStimulus(2'b11, 1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b0,
                      32'h8000_0000, 5'd31, 1'b1, 1'b1);
        #1;
        checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_res_valid", 32'(resValid), 32'h0);
        checkOutput("rst_res_sh", resSh, 32'h0);
        checkOutput("rst_res_id", 32'(resId), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both valid, result drained every cycle: alternating grants, no bubbles.
        for (int k = 0; k < 6; k++) begin
            expReady = (k % 2 == 0) ? 2'b01 : 2'b10;
            expSh    = (k % 2 == 0) ? 32'h0000_0F00 : 32'hFFFF_FFFF;
            #1;
            checkOutput($sformatf("rr_ready_%0d", k), 32'(reqReady), 32'(expReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("rr_valid_%0d", k), 32'(resValid), 32'h1);
            checkOutput($sformatf("rr_id_%0d", k), 32'(resId), 32'(k % 2));
            checkOutput($sformatf("rr_sh_%0d", k), resSh, expSh);
            @(negedge clk);
        end

        // No request, drain: slot empties.
        reqValid = 2'b00;
        #1;
        checkOutput("drain_ready", 32'(reqReady), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 32'(resValid), 32'h0);

        // Fill, then stall three cycles with requests pending.
        @(negedge clk);
        reqValid = 2'b11;
        resReady = 1'b1;
        #1;
        checkOutput("fill_ready", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("fill_id", 32'(resId), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            resReady = 1'b0;
            reqD[31:0] = 32'hDEAD_BEEF;
            #1;
            checkOutput($sformatf("stall_ready_%0d", k), 32'(reqReady), 32'h0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall_valid_%0d", k), 32'(resValid), 32'h1);
            checkOutput($sformatf("stall_sh_%0d", k), resSh, 32'h0000_0F00);
            checkOutput($sformatf("stall_id_%0d", k), 32'(resId), 32'h0);
        end
        @(negedge clk);
        resReady = 1'b1;
        #1;
        checkOutput("unstall_ready", 32'(reqReady), 32'h2);
        @(posedge clk);
        #1;
        checkOutput("unstall_valid", 32'(resValid), 32'h1);
        checkOutput("unstall_id", 32'(resId), 32'h1);
        checkOutput("unstall_sh", resSh, 32'hFFFF_FFFF);

        // Grant req0 so the pointer moves to 1, then reset while full.
        @(negedge clk);
        reqValid = 2'b01;
        #1;
        checkOutput("pre_rst_ready", 32'(reqReady), 32'h1);
        @(negedge clk);
        reqValid = 2'b11;
        resReady = 1'b0;
        #1;
        checkOutput("full_stall_ready", 32'(reqReady), 32'h0);
        checkOutput("full_stall_valid", 32'(resValid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(resValid), 32'h0);
        checkOutput("async_rst_sh", resSh, 32'h0);
        checkOutput("async_rst_ready", 32'(reqReady), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("post_rst_id", 32'(resId), 32'h0);
        checkOutput("post_rst_valid", 32'(resValid), 32'h1);

        // Single-requester shift table.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            if (vecs[v].id == 0) begin
                applyStimulus(2'b01, 1'b1, vecs[v].d, vecs[v].sa, vecs[v].right, vecs[v].arith,
                              32'h0, 5'd0, 1'b0, 1'b0);
                expReady = 2'b01;
            end else begin
                applyStimulus(2'b10, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0,
                              vecs[v].d, vecs[v].sa, vecs[v].right, vecs[v].arith);
                expReady = 2'b10;
            end
            #1;
            checkOutput($sformatf("vec%0d_ready", v), 32'(reqReady), 32'(expReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", v), 32'(resValid), 32'h1);
            checkOutput($sformatf("vec%0d_sh", v), resSh, vecs[v].expSh);
            checkOutput($sformatf("vec%0d_id", v), 32'(resId), 32'(vecs[v].id));
        end

        @(negedge clk);
        reqValid = 2'b00;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
